// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the two-port SRAM arbiter: access-state encoding,
//   default timing/fairness parameters and the SRAM address pad width.
package sram_arb_pkg;

    // Default number of extra SRAM access cycles beyond the minimum (0..7)
    localparam int WAIT_CYCLES_DEF  = 1;
    // Default max consecutive data grants while a fetch is pending (1..15)
    localparam int STARVE_LIMIT_DEF = 4;
    // Zero bits prepended to the 16-bit word address to form the 18-bit bus
    localparam int ADDR_PAD_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Arbitrates a read-only fetch port and a read/write data port onto one
//   asynchronous SRAM with active-low CE/OE/WE strobes. Data has priority;
//   a pending fetch is forced through after STARVE_LIMIT consecutive data
//   grants. One access is in flight at a time; requests are sampled in IDLE.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   fReq/fAddr/fData/fAck    fetch port (read only), ack is a 1-cycle pulse
//   dReq/dWe/dAddr/dWdata    data port request (dWe=1 write)
//   dRdata/dAck              data port read data and 1-cycle completion pulse
//   dataBus                  bidirectional SRAM data bus
//   addrBus                  SRAM address {pad, latched word address}
//   memEnable/memRead/memWrite  active-low SRAM CE/OE/WE
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES  = WAIT_CYCLES_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fReq,
    input  logic [15:0] fAddr,
    output logic [15:0] fData,
    output logic        fAck,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [15:0] dAddr,
    input  logic [15:0] dWdata,
    output logic [15:0] dRdata,
    output logic        dAck,
    inout  wire  [15:0] dataBus,
    output logic [17:0] addrBus,
    output logic        memEnable,
    output logic        memRead,
    output logic        memWrite
);

    localparam logic [2:0] WAIT_LAST  = 3'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;       // cycles spent in RD / WR_PULSE
    logic [3:0]  starve_q, starve_d;   // data grants while fetch waits
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        fwin_q, fwin_d;       // 1 = current access belongs to fetch
    logic [15:0] fdata_q, fdata_d;
    logic [15:0] drdata_q, drdata_d;

    logic        fetch_wins;
    logic        bus_drive;

    // Fetch only beats a simultaneous data request once its patience runs out.
    assign fetch_wins = fReq && (!dReq || (starve_q == STARVE_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            fwin_q   <= 1'b0;
            fdata_q  <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fwin_q   <= fwin_d;
            fdata_q  <= fdata_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fwin_d   = fwin_q;
        fdata_d  = fdata_q;
        drdata_d = drdata_q;

        unique case (state_q)
            IDLE: begin
                if (fReq || dReq) begin
                    wcnt_d = '0;
                    fwin_d = fetch_wins;
                    if (fetch_wins) begin
                        addr_d   = fAddr;
                        starve_d = '0;
                        state_d  = RD;
                    end else begin
                        addr_d   = dAddr;
                        wdata_d  = dWdata;
                        starve_d = fReq ? starve_q + 4'd1 : 4'd0;
                        // The write flag is latched as the choice of path.
                        state_d  = dWe ? WR_SETUP : RD;
                    end
                end
            end
            RD: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = DONE;
                    if (fwin_q) fdata_d  = dataBus;
                    else        drdata_d = dataBus;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
                if (wcnt_q == WAIT_LAST) state_d = WR_HOLD;
                else                     wcnt_d  = wcnt_q + 3'd1;
            end
            WR_HOLD:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so that an async reset
    // releases the SRAM in the same instant it forces IDLE.
    assign bus_drive = (state_q == WR_SETUP) || (state_q == WR_PULSE) ||
                       (state_q == WR_HOLD);
    assign memEnable = !(bus_drive || (state_q == RD));
    assign memRead   = !(state_q == RD);
    assign memWrite  = !(state_q == WR_PULSE);
    assign dataBus   = bus_drive ? wdata_q : 16'hzzzz;

    assign addrBus = {{ADDR_PAD_W{1'b0}}, addr_q};
    assign fData   = fdata_q;
    assign dRdata  = drdata_q;
    assign fAck    = (state_q == DONE) &&  fwin_q;
    assign dAck    = (state_q == DONE) && !fwin_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Drives sram_arbiter against a behavioural SRAM and a transaction-level
//   reference model (arbitration rule, shadow memory, read-data registers).
module tb_sram_arbiter;

    localparam int W  = 1;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fReq, dReq, dWe;
    logic [15:0] fAddr, dAddr, dWdata;
    logic [15:0] fData, dRdata;
    logic        fAck, dAck;
    wire  [15:0] dataBus;
    logic [17:0] addrBus;
    logic        memEnable, memRead, memWrite;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .fReq(fReq), .fAddr(fAddr), .fData(fData), .fAck(fAck),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata), .dAck(dAck),
        .dataBus(dataBus), .addrBus(addrBus),
        .memEnable(memEnable), .memRead(memRead), .memWrite(memWrite)
    );

    // ---------------- behavioural SRAM ----------------
    logic [15:0] sram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 16'(i) ^ 16'h5A5A;
        sram[16'h0040] = 16'hBEEF;
    end
    assign dataBus = (!memEnable && !memRead) ? sram[addrBus[15:0]] : 16'hzzzz;
    always @(posedge memWrite) if (rst && !memEnable) sram[addrBus[15:0]] = dataBus;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus protocol monitor ----------------
    int          viol = 0;
    int          we_run = 0;
    int          last_we_pulse = 0;
    logic [15:0] exp_wdata = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (!memRead && !memWrite) viol++;
            if (memEnable && !(dataBus === 16'hzzzz)) viol++;
            if (!memEnable && memRead && dataBus !== exp_wdata) viol++;
            if (!memWrite) we_run++;
            else if (we_run != 0) begin
                last_we_pulse = we_run;
                we_run = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [logic [15:0]];
    int          m_starve = 0;
    logic [15:0] m_fd = '0, m_dd = '0;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 16'h5A5A;
    endfunction

    typedef struct {
        int          port;   // 1 fetch, 2 data, 3 both, 0 none
        int          lat;
        logic [15:0] fd, dd;
        logic [17:0] ab;
        bit          ack_after;
    } obs_t;

    // One arbitration decision straight from the fairness rule.
    task automatic predict(input bit f, input logic [15:0] fa, input bit d, input bit we,
                           input logic [15:0] da, input logic [15:0] dwd, output obs_t e);
        bit fw;
        fw = f && (!d || m_starve == SL);
        e.ack_after = 1'b0;
        if (fw) begin
            m_starve = 0;
            e.port = 1; e.lat = W + 2; e.ab = {2'b00, fa};
            m_fd = mem_rd(fa);
        end else begin
            m_starve = f ? m_starve + 1 : 0;
            e.port = 2; e.ab = {2'b00, da};
            if (we) begin
                e.lat = W + 4;
                ref_mem[da] = dwd;
            end else begin
                e.lat = W + 2;
                m_dd = mem_rd(da);
            end
        end
        e.fd = m_fd;
        e.dd = m_dd;
    endtask

    // Called at a negedge with the DUT idle; returns at the next idle negedge.
    task automatic txn(input bit f, input logic [15:0] fa, input bit d, input bit we,
                       input logic [15:0] da, input logic [15:0] dwd, input bit hold,
                       output obs_t o);
        o.port = 0; o.lat = 0;
        fReq = f; fAddr = fa; dReq = d; dWe = we; dAddr = da; dWdata = dwd;
        if (d && we) exp_wdata = dwd;
        @(posedge clk);
        while (o.port == 0 && o.lat < 32) begin
            @(negedge clk);
            o.lat++;
            if (fAck && dAck) o.port = 3;
            else if (fAck)    o.port = 1;
            else if (dAck)    o.port = 2;
            if (!hold) begin
                fReq = 1'b0; dReq = 1'b0; dWe = 1'($urandom);
                fAddr = 16'($urandom); dAddr = 16'($urandom); dWdata = 16'($urandom);
            end
        end
        o.fd = fData; o.dd = dRdata; o.ab = addrBus;
        @(negedge clk);
        o.ack_after = fAck | dAck;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        check({tag, " port"},      32'(o.port), 32'(e.port));
        check({tag, " latency"},   32'(o.lat),  32'(e.lat));
        check({tag, " fData"},     32'(o.fd),   32'(e.fd));
        check({tag, " dRdata"},    32'(o.dd),   32'(e.dd));
        check({tag, " addrBus"},   32'(o.ab),   32'(e.ab));
        check({tag, " ack width"}, 32'(o.ack_after), 32'(e.ack_after));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          f;
        logic [15:0] fa;
        bit          d, we;
        logic [15:0] da, dwd;
        int          port, lat;
        logic [15:0] efd, edd;
        logic [17:0] eab;
    } vec_t;

    vec_t tbl [8];
    int   exp_order [10];

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin : main
        obs_t o, e;
        int   n, gap, acks;

        tbl[0] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, W+2, 16'hBEEF, 16'h0000, 18'h00040};
        tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'hA5A5, 2, W+4, 16'hBEEF, 16'h0000, 18'h01234};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000, 2, W+2, 16'hBEEF, 16'hA5A5, 18'h01234};
        tbl[3] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h1234, 16'h0000, 2, W+2, 16'hBEEF, 16'hA5A5, 18'h01234};
        tbl[4] = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, W+2, 16'hA5A5, 16'hA5A5, 18'h01234};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h1111, 2, W+4, 16'hA5A5, 16'hA5A5, 18'h00040};
        tbl[6] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, W+2, 16'h1111, 16'hA5A5, 18'h00040};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h00FF, 16'h0000, 2, W+2, 16'h1111, 16'h5AA5, 18'h000FF};
        exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        ref_mem[16'h0040] = 16'hBEEF;

        // ---- reset state ----
        rst = 1'b0; fReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        fAddr = '0; dAddr = '0; dWdata = '0;
        repeat (2) @(negedge clk);
        check("rst fAck",      32'(fAck), 0);
        check("rst dAck",      32'(dAck), 0);
        check("rst strobes",   32'({memEnable, memRead, memWrite}), 32'h7);
        check("rst addrBus",   32'(addrBus), 0);
        check("rst fData",     32'(fData), 0);
        check("rst dRdata",    32'(dRdata), 0);
        check("rst bus hi-z",  32'(dataBus === 16'hzzzz), 1);
        rst = 1'b1;
        @(negedge clk);

        // ---- table: single transactions, constant expectations ----
        for (int i = 0; i < 8; i++) begin
            last_we_pulse = 0;
            predict(tbl[i].f, tbl[i].fa, tbl[i].d, tbl[i].we, tbl[i].da, tbl[i].dwd, e);
            txn(tbl[i].f, tbl[i].fa, tbl[i].d, tbl[i].we, tbl[i].da, tbl[i].dwd, 1'b0, o);
            check($sformatf("tbl%0d port", i),    32'(o.port), 32'(tbl[i].port));
            check($sformatf("tbl%0d latency", i), 32'(o.lat),  32'(tbl[i].lat));
            check($sformatf("tbl%0d fData", i),   32'(o.fd),   32'(tbl[i].efd));
            check($sformatf("tbl%0d dRdata", i),  32'(o.dd),   32'(tbl[i].edd));
            check($sformatf("tbl%0d addrBus", i), 32'(o.ab),   32'(tbl[i].eab));
            check($sformatf("tbl%0d ack width", i), 32'(o.ack_after), 0);
            if (tbl[i].d && tbl[i].we)
                check($sformatf("tbl%0d we pulse", i), 32'(last_we_pulse), 32'(W + 1));
        end

        // ---- reset in the second WR_PULSE cycle aborts the write ----
        fReq = 1'b0; dReq = 1'b1; dWe = 1'b1; dAddr = 16'h7777; dWdata = 16'h3C3C;
        exp_wdata = 16'h3C3C;
        @(posedge clk);                 // grant
        @(negedge clk); dReq = 1'b0;
        @(posedge clk);                 // first WR_PULSE cycle
        @(posedge clk);                 // second WR_PULSE cycle
        #2;
        check("abort pre we", 32'(memWrite), 0);
        rst = 1'b0;
        #1;
        check("abort memWrite",  32'(memWrite), 1);
        check("abort memEnable", 32'(memEnable), 1);
        check("abort bus hi-z",  32'(dataBus === 16'hzzzz), 1);
        check("abort addrBus",   32'(addrBus), 0);
        check("abort dRdata",    32'(dRdata), 0);
        check("abort fData",     32'(fData), 0);
        m_starve = 0; m_fd = '0; m_dd = '0;
        acks = 0;
        repeat (2) begin @(negedge clk); acks += int'(fAck) + int'(dAck); end
        @(posedge clk); #2 rst = 1'b1;
        repeat (6) begin @(negedge clk); acks += int'(fAck) + int'(dAck); end
        check("abort no ack", 32'(acks), 0);

        // ---- both ports held: starvation bound ----
        for (int i = 0; i < 10; i++) begin
            predict(1'b1, 16'h0040, 1'b1, 1'b0, 16'h1234, 16'h0000, e);
            txn(1'b1, 16'h0040, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, o);
            check($sformatf("starve%0d order", i), 32'(o.port), 32'(exp_order[i]));
            compare($sformatf("starve%0d", i), o, e);
        end

        // ---- back-to-back data reads, address replaced at the DONE edge ----
        fReq = 1'b0; dReq = 1'b1; dWe = 1'b0; dAddr = 16'h1234;
        predict(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000, e);
        @(posedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (!dAck && n < 32);
        check("b2b first latency", 32'(n), 32'(W + 2));
        check("b2b first data",    32'(dRdata), 32'(e.dd));
        @(posedge clk);
        dAddr = 16'h0040;
        predict(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, e);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!dAck && gap < 32);
        check("b2b ack gap",     32'(gap - 1), 32'(W + 2));
        check("b2b second data", 32'(dRdata), 32'(e.dd));
        check("b2b addrBus",     32'(addrBus), 32'(e.ab));
        @(posedge clk);
        dReq = 1'b0;
        @(negedge clk);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 200; i++) begin
            bit          f, d, we, hold;
            logic [15:0] fa, da, dwd;
            f    = 1'($urandom_range(0, 1));
            d    = 1'($urandom_range(0, 1));
            if (!f && !d) d = 1'b1;
            we   = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            fa   = 16'($urandom_range(0, 7));
            da   = 16'($urandom_range(0, 7));
            dwd  = 16'($urandom);
            last_we_pulse = 0;
            predict(f, fa, d, we, da, dwd, e);
            txn(f, fa, d, we, da, dwd, hold, o);
            compare($sformatf("rnd%0d", i), o, e);
        end

        check("bus protocol violations", 32'(viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra SRAM access cycles beyond the minimum (range 0..7).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data-port grants while a fetch request is pending (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port fReq, input, 1 bit: fetch-port read request (read-only port).
REQ-006 SHALL have port fAddr, input, 16 bits: fetch word address.
REQ-007 SHALL have port fData, output, 16 bits: fetch read data.
REQ-008 SHALL have port fAck, output, 1 bit: fetch completion pulse.
REQ-009 SHALL have port dReq, input, 1 bit: data-port request.
REQ-010 SHALL have port dWe, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port dAddr, input, 16 bits: data word address.
REQ-012 SHALL have port dWdata, input, 16 bits: write data.
REQ-013 SHALL have port dRdata, output, 16 bits: data-port read data.
REQ-014 SHALL have port dAck, output, 1 bit: data-port completion pulse.
REQ-015 SHALL have port dataBus, inout, 16 bits: SRAM data bus.
REQ-016 SHALL have port addrBus, output, 18 bits: SRAM address, equal to {2'b00, latched addr}.
REQ-017 SHALL have ports memEnable, memRead and memWrite, each output, 1 bit, active-low SRAM CE/OE/WE.

Function
REQ-018 SHALL implement states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-019 SHALL sample requests only in IDLE; on grant it SHALL latch the address, write data, write flag and winner at that edge.
REQ-020 Arbitration SHALL give data priority; fetch wins when only fReq is high, or when both are high and the starvation counter equals STARVE_LIMIT.
REQ-021 The starvation counter SHALL increment on each data grant made while fReq is high, and SHALL clear on every fetch grant or whenever fReq is low at an IDLE grant.
REQ-022 A read SHALL stay in RD for WAIT_CYCLES+1 cycles with memEnable=0 and memRead=0, and SHALL capture dataBus into the winner's read-data register on the final RD edge.
REQ-023 A write SHALL run WR_SETUP for 1 cycle (memEnable=0), then WR_PULSE for WAIT_CYCLES+1 cycles (memWrite=0), then WR_HOLD for 1 cycle (memWrite=1); dataBus SHALL be driven with the latched data in all three states.
REQ-024 dataBus SHALL be high-Z in every state other than WR_SETUP, WR_PULSE and WR_HOLD; memRead and memWrite SHALL never be low in the same cycle.
REQ-025 DONE SHALL last exactly 1 cycle with only the winner's ack high, then go to IDLE; the requester SHALL drop or replace its request at the edge that ends DONE.
REQ-026 Read latency SHALL be WAIT_CYCLES+2 cycles from grant edge to ack; write latency SHALL be WAIT_CYCLES+4 cycles.
REQ-027 fData and dRdata SHALL hold their last captured value until the next read by the same port; a write SHALL not alter dRdata.
REQ-028 Requester inputs SHALL be ignored outside IDLE; changes mid-transaction SHALL have no effect on the access in flight.

Reset
REQ-029 On rst=0 the block SHALL immediately enter IDLE, set fAck=dAck=0, memEnable=memRead=memWrite=1, release dataBus to high-Z, and set addrBus=0, fData=dRdata=0 and the starvation counter to 0.
REQ-030 Reset during any state, including mid-write, SHALL abort the access with no ack.

Structure
REQ-031 SHALL place the state enumeration, the WAIT_CYCLES and STARVE_LIMIT defaults, and the address pad width in shared package sram_arb_pkg.
REQ-032 SHALL be a single module with no sub-module; the tristate driver SHALL be inline.

Verification
REQ-033 Fetch read, WAIT_CYCLES=1, fAddr=0x0040, SRAM model returns 0xBEEF -> fAck high 3 cycles after grant, fData=0xBEEF, addrBus=0x00040.
REQ-034 Data write dAddr=0x1234, dWdata=0xA5A5, then data read of 0x1234 -> memWrite low exactly 2 cycles, bus high-Z outside write states, dRdata=0xA5A5.
REQ-035 fReq and dReq held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F repeating, each ack a 1-cycle pulse with no double issue.
REQ-036 rst pulled low in the 2nd WR_PULSE cycle -> memWrite=1 and dataBus high-Z asynchronously, no dAck, IDLE after release.
REQ-037 Back-to-back data reads with dReq held and dAddr changed at the DONE edge -> second grant on the edge after DONE; dAck pulses separated by WAIT_CYCLES+2 cycles.
